// File: rtl/my_pkg.sv
// Shared widths, memory-operation encodings and arbiter state type for the
// instruction/data memory arbiter.
package my_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // Size/sign codes carried on d_op / m_op.
    typedef enum logic [2:0] {
        MEM_OP_B  = 3'b000,
        MEM_OP_H  = 3'b001,
        MEM_OP_W  = 3'b010,
        MEM_OP_BU = 3'b100,
        MEM_OP_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with one transaction
// outstanding; data has priority unless fetch has lost STARVE_LIMIT times.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = my_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = my_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_op,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  m_req,
    output logic                  m_we,
    output logic [2:0]            m_op,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);
    import my_pkg::*;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             pick_if;

    // NOTE: state registers use non-blocking assignments and the async reset
    // branch; the combinational block below uses blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        starve_d  = starve_q;
        pick_if   = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_op      = '0;
        m_addr    = '0;
        m_wdata   = '0;

        // Outputs are combinational from the inputs, so reset must mask them too.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    pick_if = if_req && (!d_req || starve_q == CNT_MAX);
                    if (if_req || d_req) begin
                        m_req = 1'b1;
                        if (pick_if) begin
                            m_op   = MEM_OP_W;
                            m_addr = if_addr;
                        end else begin
                            m_we    = d_we;
                            m_op    = d_op;
                            m_addr  = d_addr;
                            m_wdata = d_wdata;
                        end
                        if (m_ready) begin
                            if_gnt  = pick_if;
                            d_gnt   = !pick_if;
                            state_d = pick_if ? BUSY_I : BUSY_D;
                        end
                    end
                end
                BUSY_I: begin
                    if (m_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = m_rdata;
                        state_d   = IDLE;
                    end
                end
                BUSY_D: begin
                    if (m_rvalid) begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Count data wins that happened while fetch was waiting.
            if (!if_req || if_gnt) begin
                starve_d = '0;
            end else if (d_gnt && starve_q != CNT_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected grant and
// response events; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;
    import my_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef enum logic [2:0] {K_IGNT, K_DGNT, K_IRV, K_DRV, K_NONE} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  op;
        logic [31:0] rdata;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [2:0]    d_op;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [2:0]    m_op;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready, m_rvalid;
    logic [DW-1:0] m_rdata;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_op     (d_op),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_op     (m_op),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input kind_e k, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic [2:0] op);
        ev_t e;
        e.kind = k; e.addr = addr; e.wdata = wdata; e.we = we; e.op = op; e.rdata = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_rv(input kind_e k, input logic [31:0] data);
        ev_t e;
        e.kind = k; e.addr = '0; e.wdata = '0; e.we = 1'b0; e.op = '0; e.rdata = data;
        exp_q.push_back(e);
    endtask

    task automatic compare(input kind_e k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("spurious_event", 32'(k), 32'(K_NONE));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k == e.kind) begin
                case (k)
                    K_IGNT: begin
                        check("if_gnt_addr", m_addr, e.addr);
                        check("if_gnt_we", 32'(m_we), 32'(e.we));
                        check("if_gnt_op", 32'(m_op), 32'(e.op));
                    end
                    K_DGNT: begin
                        check("d_gnt_addr", m_addr, e.addr);
                        check("d_gnt_we", 32'(m_we), 32'(e.we));
                        check("d_gnt_op", 32'(m_op), 32'(e.op));
                        check("d_gnt_wdata", m_wdata, e.wdata);
                    end
                    K_IRV:   check("if_rdata", if_rdata, e.rdata);
                    default: check("d_rdata", d_rdata, e.rdata);
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (if_gnt || d_gnt) check("single_gnt", 32'(if_gnt & d_gnt), 32'd0);
            if (!if_rvalid) check("if_rdata_when_idle", if_rdata, 32'd0);
            if (!d_rvalid) check("d_rdata_when_idle", d_rdata, 32'd0);
            if (if_gnt)    compare(K_IGNT);
            if (d_gnt)     compare(K_DGNT);
            if (if_rvalid) compare(K_IRV);
            if (d_rvalid)  compare(K_DRV);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, 32'(m_req), 32'd0);
        check({tag, "_m_we"}, 32'(m_we), 32'd0);
        check({tag, "_m_op"}, 32'(m_op), 32'd0);
        check({tag, "_m_addr"}, m_addr, 32'd0);
        check({tag, "_m_wdata"}, m_wdata, 32'd0);
        check({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
        check({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // Reset with every request and memory input active: outputs must stay 0.
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b1; d_op = 3'b001;
        d_addr = 32'h88; d_wdata = 32'h55; m_ready = 1'b1; m_rvalid = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        sample();
        check_all_zero("reset");
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // Fetch only; a data request during BUSY_I must not reach the memory.
        push_gnt(K_IGNT, 32'h10, 32'h0, 1'b0, MEM_OP_W);
        push_rv(K_IRV, 32'h0050_0093);
        if_req = 1'b1; if_addr = 32'h10; m_ready = 1'b1;
        tick();
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h70;
        sample();
        check("busy_i_m_req", 32'(m_req), 32'd0);
        tick();
        d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
        tick();
        m_rvalid = 1'b0;
        tick();

        // Simultaneous fetch and load: data first, fetch in the IDLE after d_rvalid.
        push_gnt(K_DGNT, 32'h40, 32'h0, 1'b0, MEM_OP_BU);
        push_rv(K_DRV, 32'hDEAD_0001);
        push_gnt(K_IGNT, 32'h20, 32'h0, 1'b0, MEM_OP_W);
        push_rv(K_IRV, 32'h1111_1111);
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_op = MEM_OP_BU; d_addr = 32'h40; m_ready = 1'b1;
        tick();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_0001;
        tick();
        m_rvalid = 1'b0;
        tick();
        if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
        tick();
        idle_inputs();
        tick();

        // Continuous contention, latency 1: four data wins, fetch fifth, then data again.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                push_gnt(K_IGNT, 32'h30, 32'h0, 1'b0, MEM_OP_W);
                push_rv(K_IRV, 32'hA000_0000 + 32'(i));
            end else begin
                push_gnt(K_DGNT, 32'h50, 32'h0, 1'b0, MEM_OP_W);
                push_rv(K_DRV, 32'hA000_0000 + 32'(i));
            end
        end
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_op = MEM_OP_W; d_addr = 32'h50; m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_rvalid = 1'b0;
            tick();
            m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + 32'(i);
            tick();
        end
        idle_inputs();
        tick();

        // Memory stalls: owner changes when data joins, fields held, then store acked.
        push_gnt(K_DGNT, 32'h80, 32'hAB, 1'b1, MEM_OP_B);
        push_rv(K_DRV, 32'h0);
        push_gnt(K_IGNT, 32'h60, 32'h0, 1'b0, MEM_OP_W);
        push_rv(K_IRV, 32'h99);
        if_req = 1'b1; if_addr = 32'h60; m_ready = 1'b0;
        sample();
        check("stall_fetch_m_req", 32'(m_req), 32'd1);
        check("stall_fetch_m_addr", m_addr, 32'h60);
        check("stall_fetch_m_op", 32'(m_op), 32'(MEM_OP_W));
        tick();
        d_req = 1'b1; d_we = 1'b1; d_op = MEM_OP_B; d_addr = 32'h80; d_wdata = 32'hAB;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_m_req", 32'(m_req), 32'd1);
            check("stall_m_we", 32'(m_we), 32'd1);
            check("stall_m_op", 32'(m_op), 32'(MEM_OP_B));
            check("stall_m_addr", m_addr, 32'h80);
            check("stall_m_wdata", m_wdata, 32'hAB);
            check("stall_d_gnt", 32'(d_gnt), 32'd0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0; m_ready = 1'b0;
        sample();
        check("store_wait_d_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0;
        tick();
        m_rvalid = 1'b0; m_ready = 1'b1;
        tick();
        if_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h99;
        tick();
        idle_inputs();
        tick();

        // Reset in BUSY_D, then a late m_rvalid: no d_rvalid, state back to IDLE.
        push_gnt(K_DGNT, 32'h90, 32'h0, 1'b0, MEM_OP_W);
        d_req = 1'b1; d_op = MEM_OP_W; d_addr = 32'h90; m_ready = 1'b1;
        tick();
        d_req = 1'b0; m_ready = 1'b0;
        tick();
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h44; m_ready = 1'b1;
        sample();
        check_all_zero("mid_reset");
        tick();
        rst_n = 1'b1; if_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        sample();
        check("late_rvalid_d_rvalid", 32'(d_rvalid), 32'd0);
        check("late_rvalid_if_rvalid", 32'(if_rvalid), 32'd0);
        check("late_rvalid_d_rdata", d_rdata, 32'd0);
        tick();
        push_gnt(K_IGNT, 32'h44, 32'h0, 1'b0, MEM_OP_W);
        push_rv(K_IRV, 32'h77);
        m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h44; m_ready = 1'b1;
        sample();
        check("post_reset_idle_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
        tick();
        idle_inputs();
        tick();

        // Stray m_rvalid in IDLE with no request.
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        sample();
        check("idle_rvalid_if_rvalid", 32'(if_rvalid), 32'd0);
        check("idle_rvalid_d_rvalid", 32'(d_rvalid), 32'd0);
        check("idle_rvalid_m_req", 32'(m_req), 32'd0);
        tick();
        push_gnt(K_DGNT, 32'hA0, 32'h0, 1'b0, MEM_OP_H);
        push_rv(K_DRV, 32'hCAFE);
        m_rvalid = 1'b0; d_req = 1'b1; d_op = MEM_OP_H; d_addr = 32'hA0; m_ready = 1'b1;
        sample();
        check("after_stray_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE;
        tick();
        idle_inputs();

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
